// File: rtl/result_stage_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_seq_pkg : shared encodings for the MFCC result-stage sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package result_seq_pkg;

  localparam int DEFAULT_NUM_STAGES  = 5;
  localparam int DEFAULT_SEL_WIDTH   = 3;
  localparam int DEFAULT_FRAME_WIDTH = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_NEXT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LAUNCH = ST_LAUNCH,
    WAIT   = ST_WAIT,
    NEXT   = ST_NEXT,
    FINISH = ST_FINISH
  } state_t;

  // Result-mux input ordering, one per pipeline stage
  localparam logic [DEFAULT_SEL_WIDTH-1:0] SEL_FRAME = 3'd0;
  localparam logic [DEFAULT_SEL_WIDTH-1:0] SEL_FFT   = 3'd1;
  localparam logic [DEFAULT_SEL_WIDTH-1:0] SEL_MEL   = 3'd2;
  localparam logic [DEFAULT_SEL_WIDTH-1:0] SEL_LOG   = 3'd3;
  localparam logic [DEFAULT_SEL_WIDTH-1:0] SEL_DCT   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/result_stage_sequencer_next_finder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stage_next_finder : lowest enabled stage index strictly above cur
// Revision: 1.0
// ---------------------------------------------------------------------------
module stage_next_finder
  import result_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH
) (
  input  logic [NUM_STAGES-1:0] mask,
  input  logic [SEL_WIDTH-1:0]  cur,
  output logic [SEL_WIDTH-1:0]  next_idx,
  output logic                  found
);

  // cur of all-ones means "before stage 0", giving a first-enabled lookup
  logic before_first;
  assign before_first = &cur;

  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (mask[k] && (before_first || (SEL_WIDTH'(k) > cur))) begin
        next_idx = SEL_WIDTH'(k);
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_stage_sequencer : launches MFCC stages frame by frame, owns result mux
// Revision: 1.0
// ---------------------------------------------------------------------------
module result_stage_sequencer
  import result_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
  parameter int SEL_WIDTH   = DEFAULT_SEL_WIDTH,
  parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FRAME_WIDTH-1:0] num_frames,
  input  logic [NUM_STAGES-1:0]  stage_en,
  input  logic [NUM_STAGES-1:0]  stage_done,
  output logic [NUM_STAGES-1:0]  stage_start,
  output logic [SEL_WIDTH-1:0]   addr_sel,
  output logic [FRAME_WIDTH-1:0] frame_idx,
  output logic                   busy,
  output logic                   all_done,
  output logic                   err
);

  state_t                 state;
  logic [SEL_WIDTH-1:0]   cur;
  logic [FRAME_WIDTH-1:0] frames_q;
  logic [NUM_STAGES-1:0]  mask_q;

  logic [NUM_STAGES-1:0]  first_mask;
  logic [SEL_WIDTH-1:0]   first_idx;
  logic                   first_found;
  logic [SEL_WIDTH-1:0]   next_idx;
  logic                   next_found;
  logic [NUM_STAGES-1:0]  cur_onehot;
  logic                   cur_done;
  logic                   foreign_done;
  logic                   last_frame;

  // In IDLE the mask is not latched yet, so look at the live request
  assign first_mask = (state == IDLE) ? stage_en : mask_q;

  stage_next_finder #(
    .NUM_STAGES (NUM_STAGES),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_first (
    .mask     (first_mask),
    .cur      ({SEL_WIDTH{1'b1}}),
    .next_idx (first_idx),
    .found    (first_found)
  );

  stage_next_finder #(
    .NUM_STAGES (NUM_STAGES),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_next (
    .mask     (mask_q),
    .cur      (cur),
    .next_idx (next_idx),
    .found    (next_found)
  );

  assign cur_onehot   = NUM_STAGES'(1) << cur;
  assign cur_done     = |(stage_done & cur_onehot);
  assign foreign_done = |(stage_done & ~cur_onehot);
  assign last_frame   = (frame_idx == (frames_q - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      frames_q    <= '0;
      mask_q      <= '0;
      stage_start <= '0;
      addr_sel    <= '0;
      frame_idx   <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      err         <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // err is deliberately kept so software can see why the run stopped
      state       <= IDLE;
      cur         <= '0;
      stage_start <= '0;
      addr_sel    <= '0;
      frame_idx   <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      stage_start <= '0;
      all_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ((num_frames != '0) && first_found) begin
              frames_q    <= num_frames;
              mask_q      <= stage_en;
              frame_idx   <= '0;
              cur         <= first_idx;
              addr_sel    <= first_idx;
              stage_start <= NUM_STAGES'(1) << first_idx;
              busy        <= 1'b1;
              err         <= 1'b0;
              state       <= LAUNCH;
            end else begin
              all_done <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (|stage_done) err <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (foreign_done) err <= 1'b1;
          if (cur_done) state <= NEXT;
        end
        NEXT: begin
          if (next_found) begin
            cur         <= next_idx;
            addr_sel    <= next_idx;
            stage_start <= NUM_STAGES'(1) << next_idx;
            state       <= LAUNCH;
          end else if (last_frame) begin
            all_done <= 1'b1;
            busy     <= 1'b0;
            addr_sel <= '0;
            cur      <= '0;
            state    <= FINISH;
          end else begin
            frame_idx   <= frame_idx + 1'b1;
            cur         <= first_idx;
            addr_sel    <= first_idx;
            stage_start <= NUM_STAGES'(1) << first_idx;
            state       <= LAUNCH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_result_stage_sequencer : vector table + launch scoreboard for the sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_result_stage_sequencer;

  localparam int NS       = 5;
  localparam int SW       = 3;
  localparam int FW       = 16;
  localparam int DONE_LAT = 3;
  localparam int BUDGET   = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [FW-1:0] num_frames;
  logic [NS-1:0] stage_en;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] stage_start;
  logic [SW-1:0] addr_sel;
  logic [FW-1:0] frame_idx;
  logic          busy;
  logic          all_done;
  logic          err;

  typedef struct { int stage; int frame; } launch_t;
  typedef struct { int frames; logic [NS-1:0] en; logic exp_err; } vec_t;

  launch_t       exp_q[$];
  vec_t          vecs[8];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            ad_cnt = 0;
  int            ref_cyc = 0;
  int            ref_gap = 0;
  int            cnt[NS];
  logic          auto_resp;
  logic [NS-1:0] inj;

  result_stage_sequencer #(
    .NUM_STAGES  (NS),
    .SEL_WIDTH   (SW),
    .FRAME_WIDTH (FW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_frames  (num_frames),
    .stage_en    (stage_en),
    .stage_done  (stage_done),
    .stage_start (stage_start),
    .addr_sel    (addr_sel),
    .frame_idx   (frame_idx),
    .busy        (busy),
    .all_done    (all_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_launch();
    launch_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_launch", longint'(stage_start), 0);
    end else begin
      e = exp_q.pop_front();
      chk("stage_start", longint'(stage_start), longint'(1) << e.stage);
      chk("addr_sel", longint'(addr_sel), e.stage);
      chk("frame_idx", longint'(frame_idx), e.frame);
    end
    if (ref_gap != 0) chk("launch_latency", cyc - ref_cyc, ref_gap);
    ref_gap = 0;
  endtask

  // One cycle: observe outputs on the falling edge, then model the stages
  task automatic tick();
    logic [NS-1:0] d;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (all_done) ad_cnt++;
    if (stage_start != '0) check_launch();
    d   = inj;
    inj = '0;
    for (int k = 0; k < NS; k++) begin
      if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) begin
          d[k] = 1'b1;
          chk("addr_sel_at_done", longint'(addr_sel), k);
          ref_cyc = cyc;
          ref_gap = 2;
        end
      end
    end
    if (auto_resp)
      for (int k = 0; k < NS; k++)
        if (stage_start[k]) cnt[k] = DONE_LAT;
    stage_done = d;
  endtask

  task automatic push_run(input int frames, input logic [NS-1:0] en);
    for (int f = 0; f < frames; f++)
      for (int k = 0; k < NS; k++)
        if (en[k]) exp_q.push_back('{stage: k, frame: f});
  endtask

  task automatic issue_start(input int frames, input logic [NS-1:0] en, input logic with_abort);
    tick();
    start      = 1'b1;
    abort      = with_abort;
    num_frames = FW'(frames);
    stage_en   = en;
    ref_cyc    = cyc;
    ref_gap    = 1;
  endtask

  task automatic clear_stages();
    exp_q.delete();
    for (int k = 0; k < NS; k++) cnt[k] = 0;
  endtask

  task automatic run_vec(input vec_t v, input logic with_abort);
    int n0;
    push_run(v.frames, v.en);
    n0 = ad_cnt;
    issue_start(v.frames, v.en, with_abort);
    tick();
    if ((v.frames == 0) || (v.en == '0)) begin
      chk("degen_all_done", longint'(all_done), 1);
      chk("degen_busy", longint'(busy), 0);
      chk("degen_no_launch", longint'(stage_start), 0);
      ref_gap = 0;
      tick();
      chk("degen_pulse_once", longint'(all_done), 0);
      chk("degen_busy_later", longint'(busy), 0);
    end else begin
      chk("busy_after_start", longint'(busy), 1);
      chk("err_cleared", longint'(err), 0);
      for (int i = 0; (i < BUDGET) && (ad_cnt == n0); i++) tick();
      chk("run_completed", ad_cnt - n0, 1);
      chk("finish_busy", longint'(busy), 0);
      chk("finish_addr_sel", longint'(addr_sel), 0);
      chk("final_err", longint'(err), longint'(v.exp_err));
      chk("launches_left", exp_q.size(), 0);
      repeat (3) tick();
      chk("all_done_once", ad_cnt - n0, 1);
    end
    clear_stages();
  endtask

  initial begin
    int n0;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    num_frames = '0;
    stage_en   = '0;
    stage_done = '0;
    inj        = '0;
    auto_resp  = 1'b1;
    for (int k = 0; k < NS; k++) cnt[k] = 0;

    vecs[0] = '{frames: 2, en: 5'b11111, exp_err: 1'b0};
    vecs[1] = '{frames: 1, en: 5'b10101, exp_err: 1'b0};
    vecs[2] = '{frames: 0, en: 5'b11111, exp_err: 1'b0};
    vecs[3] = '{frames: 3, en: 5'b00001, exp_err: 1'b0};
    vecs[4] = '{frames: 1, en: 5'b10000, exp_err: 1'b0};
    vecs[5] = '{frames: 1, en: 5'b00000, exp_err: 1'b0};
    vecs[6] = '{frames: 2, en: 5'b01010, exp_err: 1'b0};
    vecs[7] = '{frames: 4, en: 5'b11011, exp_err: 1'b0};

    #1;
    chk("rst_stage_start", longint'(stage_start), 0);
    chk("rst_addr_sel", longint'(addr_sel), 0);
    chk("rst_frame_idx", longint'(frame_idx), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_all_done", longint'(all_done), 0);
    chk("rst_err", longint'(err), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // Foreign done while waiting on stage 1 flags err but does not advance
    push_run(1, 5'b11111);
    n0 = ad_cnt;
    issue_start(1, 5'b11111, 1'b0);
    for (int i = 0; (i < BUDGET) && (exp_q.size() > 3); i++) tick();
    inj = 5'b01000;
    tick();
    tick();
    chk("err_set", longint'(err), 1);
    chk("err_still_busy", longint'(busy), 1);
    chk("err_addr_sel_held", longint'(addr_sel), 1);
    for (int i = 0; (i < BUDGET) && (ad_cnt == n0); i++) tick();
    chk("err_run_completed", ad_cnt - n0, 1);
    chk("err_launches_left", exp_q.size(), 0);
    chk("err_sticky", longint'(err), 1);
    clear_stages();
    repeat (2) tick();
    run_vec(vecs[1], 1'b0);

    // Abort in WAIT of stage 2, frame 1
    push_run(2, 5'b11111);
    n0 = ad_cnt;
    issue_start(2, 5'b11111, 1'b0);
    for (int i = 0; (i < BUDGET) && (exp_q.size() > 2); i++) tick();
    tick();
    abort = 1'b1;
    tick();
    chk("abort_busy", longint'(busy), 0);
    chk("abort_addr_sel", longint'(addr_sel), 0);
    chk("abort_frame_idx", longint'(frame_idx), 0);
    chk("abort_stage_start", longint'(stage_start), 0);
    chk("abort_all_done", longint'(all_done), 0);
    clear_stages();
    repeat (10) tick();
    chk("abort_no_all_done", ad_cnt - n0, 0);
    run_vec(vecs[0], 1'b0);

    // Abort coinciding with start in IDLE: start wins
    run_vec(vecs[6], 1'b1);

    // Asynchronous reset mid-run
    push_run(1, 5'b11111);
    n0 = ad_cnt;
    issue_start(1, 5'b11111, 1'b0);
    for (int i = 0; (i < BUDGET) && (exp_q.size() > 2); i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stage_start", longint'(stage_start), 0);
    chk("arst_addr_sel", longint'(addr_sel), 0);
    chk("arst_frame_idx", longint'(frame_idx), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_all_done", longint'(all_done), 0);
    chk("arst_err", longint'(err), 0);
    clear_stages();
    ref_gap = 0;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("arst_no_all_done", ad_cnt - n0, 0);
    chk("arst_idle_busy", longint'(busy), 0);
    run_vec(vecs[7], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
